// File: rtl/debug_tx_framer.sv
// rtl/debug_tx_framer.sv - debug word FIFO and 7-byte frame serializer with FWFT byte output
module debug_tx_framer #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_id,
  input  logic [31:0] wr_data,
  output logic        tx_empty,
  output logic [7:0]  tx_dout,
  input  logic        tx_rd_en,
  output logic        busy,
  output logic [7:0]  frame_count,
  output logic        overflow_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_D0   = 3'd3;
  localparam logic [2:0] S_D1   = 3'd4;
  localparam logic [2:0] S_D2   = 3'd5;
  localparam logic [2:0] S_D3   = 3'd6;
  localparam logic [2:0] S_CSUM = 3'd7;

  // Each entry is {id, data}.
  logic [37:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        fifo_empty;
  logic        fifo_full;
  logic        wr_accept;
  logic        byte_pop;
  logic        load;
  logic        frame_done;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [5:0]  frame_id;
  logic [31:0] frame_data;
  logic [7:0]  csum;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ready   = !fifo_full;
  assign wr_accept  = wr_valid && !fifo_full;

  // The byte interface is empty exactly when no frame is being presented.
  assign tx_empty   = (state == S_IDLE);
  assign byte_pop   = tx_rd_en && !tx_empty;
  assign frame_done = (state == S_CSUM) && byte_pop;

  // Load the frame register from idle, or straight after the checksum pop so frames run back to back.
  assign load = !fifo_empty && ((state == S_IDLE) || frame_done);
  assign busy = !tx_empty || !fifo_empty;

  assign csum = {2'b00, frame_id} ^ frame_data[7:0] ^ frame_data[15:8]
              ^ frame_data[23:16] ^ frame_data[31:24];

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= {wr_id, wr_data};
    end
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_valid && fifo_full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Serializer next-state: bytes advance only when the transmitter pops.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = S_SYNC;
        end
      end
      S_CSUM: begin
        if (byte_pop) begin
          state_nxt = fifo_empty ? S_IDLE : S_SYNC;
        end
      end
      default: begin
        if (byte_pop) begin
          state_nxt = state + 3'd1;
        end
      end
    endcase
  end

  // Serializer state, frame register and completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      frame_id    <= '0;
      frame_data  <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        {frame_id, frame_data} <= mem[rd_ptr[AW-1:0]];
      end
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Byte selected by the current state; idle drives zero.
  always_comb begin
    tx_dout = 8'h00;
    case (state)
      S_SYNC:  tx_dout = SYNC_BYTE;
      S_ID:    tx_dout = {2'b00, frame_id};
      S_D0:    tx_dout = frame_data[7:0];
      S_D1:    tx_dout = frame_data[15:8];
      S_D2:    tx_dout = frame_data[23:16];
      S_D3:    tx_dout = frame_data[31:24];
      S_CSUM:  tx_dout = csum;
      default: tx_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_debug_tx_framer.sv
// tb/tb_debug_tx_framer.sv - self-checking bench for debug_tx_framer
module tb_debug_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_id = '0;
  logic [31:0] wr_data = '0;
  logic        tx_rd_en = 1'b0;
  logic        wr_ready;
  logic        tx_empty;
  logic [7:0]  tx_dout;
  logic        busy;
  logic [7:0]  frame_count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  id;
    logic [31:0] data;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  debug_tx_framer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_id        (wr_id),
    .wr_data      (wr_data),
    .tx_empty     (tx_empty),
    .tx_dout      (tx_dout),
    .tx_rd_en     (tx_rd_en),
    .busy         (busy),
    .frame_count  (frame_count),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_csum(input logic [5:0] id, input logic [31:0] d);
    return {2'b00, id} ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  function automatic logic [7:0] fbyte(input logic [5:0] id, input logic [31:0] d,
                                       input logic [7:0] cs, input int k);
    case (k)
      0:       return 8'hA5;
      1:       return {2'b00, id};
      2:       return d[7:0];
      3:       return d[15:8];
      4:       return d[23:16];
      5:       return d[31:24];
      default: return cs;
    endcase
  endfunction

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic write_word(input logic [5:0] id, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_id    = id;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pop_byte(output logic [7:0] b, output int waited);
    waited = 0;
    while (tx_empty && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (tx_empty) begin
      n_cmp++;
      n_err++;
      $display("FAIL pop_timeout: tx_empty=1 after 100 cycles, required 0");
    end
    b = tx_dout;
    tx_rd_en = 1'b1;
    @(negedge clk);
    tx_rd_en = 1'b0;
  endtask

  task automatic pop_frame(input logic [5:0] id, input logic [31:0] d, input logic [7:0] cs,
                           input string name, input bit no_gap);
    logic [7:0] b;
    int w;
    for (int k = 0; k < 7; k++) begin
      pop_byte(b, w);
      chk($sformatf("%s_byte%0d", name, k), b, fbyte(id, d, cs, k));
      if (no_gap) chk($sformatf("%s_gap%0d", name, k), w, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int w;

    vecs[0] = '{6'h01, 32'h12345678, 8'h09};
    vecs[1] = '{6'h3F, 32'hFFFFFFFF, 8'h3F};
    vecs[2] = '{6'h00, 32'h00000000, 8'h00};
    vecs[3] = '{6'h2A, 32'hDEADBEEF, 8'h08};
    vecs[4] = '{6'h15, 32'h80000001, 8'h94};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_dout", tx_dout, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single frames with continuous pop
    for (int i = 0; i < 5; i++) begin
      write_word(vecs[i].id, vecs[i].data);
      chk("lat_empty_after_write", tx_empty, 1);
      @(negedge clk);
      chk("lat_empty_after_load", tx_empty, 0);
      pop_frame(vecs[i].id, vecs[i].data, vecs[i].csum, "vec", 1'b0);
      chk("vec_frame_count", frame_count, i + 1);
      chk("vec_busy_after", busy, 0);
    end

    // Stall: pop every third cycle, byte must hold in between
    write_word(6'h01, 32'h12345678);
    for (int k = 0; k < 7; k++) begin
      w = 0;
      while (tx_empty && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("stall_byte%0d", k), tx_dout, fbyte(6'h01, 32'h12345678, 8'h09, k));
      repeat (2) begin
        @(negedge clk);
        chk($sformatf("stall_hold%0d", k), tx_dout, fbyte(6'h01, 32'h12345678, 8'h09, k));
      end
      tx_rd_en = 1'b1;
      @(negedge clk);
      tx_rd_en = 1'b0;
    end
    chk("stall_frame_count", frame_count, 6);

    // Back-to-back: four words, no empty gap between frames
    for (int i = 0; i < 4; i++) begin
      write_word(6'(i), 32'hA0B0C0D0 + 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 4; i++) begin
      pop_frame(6'(i), 32'hA0B0C0D0 + 32'(i) * 32'h01010101,
                model_csum(6'(i), 32'hA0B0C0D0 + 32'(i) * 32'h01010101), "b2b", i > 0);
    end
    chk("b2b_frame_count", frame_count, 10);
    chk("b2b_busy_after", busy, 0);

    // Full and overflow
    for (int i = 0; i < 5; i++) begin
      write_word(6'(8 + i), 32'h10000000 + 32'(i));
    end
    chk("full_wr_ready", wr_ready, 0);
    chk("full_no_overflow_yet", overflow_err, 0);
    write_word(6'h3F, 32'hBAD0BAD0);
    chk("overflow_set", overflow_err, 1);
    chk("overflow_wr_ready", wr_ready, 0);
    for (int k = 0; k < 6; k++) begin
      pop_byte(b, w);
      chk($sformatf("ovf_f0_byte%0d", k), b, fbyte(6'd8, 32'h10000000, 8'h00, k));
    end
    chk("ovf_f0_csum", tx_dout, model_csum(6'd8, 32'h10000000));
    // Write while full in the same edge as the checksum pop: must be rejected
    wr_valid = 1'b1;
    wr_id    = 6'h3E;
    wr_data  = 32'hBAD1BAD1;
    tx_rd_en = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    tx_rd_en = 1'b0;
    chk("ovf_csum_pop_count", frame_count, 11);
    chk("ovf_rejected_wr_ready", wr_ready, 1);
    for (int i = 1; i < 5; i++) begin
      pop_frame(6'(8 + i), 32'h10000000 + 32'(i),
                model_csum(6'(8 + i), 32'h10000000 + 32'(i)), "ovf_drain", 1'b1);
    end
    repeat (3) @(negedge clk);
    chk("ovf_drain_empty", tx_empty, 1);
    chk("ovf_drain_busy", busy, 0);
    chk("ovf_drain_count", frame_count, 15);
    chk("ovf_sticky", overflow_err, 1);

    // Reset mid-frame with a second word waiting in the FIFO
    write_word(6'h05, 32'hCAFEF00D);
    write_word(6'h06, 32'h01020304);
    for (int k = 0; k < 4; k++) begin
      pop_byte(b, w);
      chk($sformatf("midrst_byte%0d", k), b, fbyte(6'h05, 32'hCAFEF00D, 8'h00, k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_empty", tx_empty, 1);
    chk("midrst_tx_dout", tx_dout, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_count", frame_count, 0);
    chk("midrst_overflow", overflow_err, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_word(vecs[3].id, vecs[3].data);
    pop_frame(vecs[3].id, vecs[3].data, vecs[3].csum, "postrst", 1'b0);
    chk("postrst_count", frame_count, 1);
    repeat (2) @(negedge clk);
    chk("postrst_empty", tx_empty, 1);

    // Wrap: 257 frames from reset, data = frame index
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 257; f++) begin
      write_word(6'(f), 32'(f));
      pop_frame(6'(f), 32'(f), model_csum(6'(f), 32'(f)), "wrap", 1'b0);
      if (f == 255) chk("wrap_count_256", frame_count, 8'h00);
      if (f == 256) chk("wrap_count_257", frame_count, 8'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_tx_framer.md
Name: debug_tx_framer

Overview:
Sits between the debug-unit control FSM and the UART transmitter. Accepts 32-bit debug words tagged with a block ID, such as PC or instruction values, and buffers them in a small word FIFO. Each word is serialized into a fixed 7-byte frame: sync, ID, four data bytes LSB-first, XOR checksum. Presents the frame bytes on a first-word-fall-through (FWFT) byte interface that the UART transmitter pops directly.

Parameters:
DEPTH, 4, word FIFO entries; power of 2, minimum 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
wr_valid  in  1  debug word offered.
wr_ready  out  1  word FIFO can accept; equals !full.
wr_id  in  6  block ID of offered word.
wr_data  in  32  debug word.
tx_empty  out  1  no frame byte available (FWFT empty).
tx_dout  out  8  current frame byte; valid only when tx_empty=0.
tx_rd_en  in  1  pop current byte (the transmitter's read-enable).
busy  out  1  frame in progress or FIFO non-empty.
frame_count  out  8  frames fully popped, modulo 256.
overflow_err  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst_n=0, async): FIFO pointers, state, frame register, frame_count and overflow_err all clear. Outputs: wr_ready=1, tx_empty=1, tx_dout=8'h00, busy=0.
- Write acceptance: a write is accepted when wr_valid & wr_ready on a clk edge; {wr_id, wr_data} is stored at the write pointer.
  - Full is computed from registered pointers. A write while full is rejected even if the serializer pops the FIFO in the same cycle.
  - A rejected write (wr_valid & !wr_ready) sets overflow_err. Only reset clears it.
- Serializer FSM states: IDLE, SYNC, ID, D0, D1, D2, D3, CSUM.
- IDLE:
  - tx_empty=1.
  - If the FIFO is non-empty: pop the head into the frame register and go to SYNC.
  - A word written at edge N is loaded at edge N+1; tx_empty falls after edge N+1.
- Per-state tx_dout:
  - SYNC: SYNC_BYTE.
  - ID: {2'b00, id}.
  - D0..D3: data[7:0], [15:8], [23:16], [31:24].
  - CSUM: XOR of the ID byte and the four data bytes.
- Advance: in SYNC..D3, tx_rd_en=1 moves to the next state; tx_rd_en=0 holds the state and tx_dout stable indefinitely.
- Ignored input: tx_rd_en while tx_empty=1 has no effect.
- CSUM pop:
  - frame_count increments, wrapping 8'hFF to 8'h00.
  - If the FIFO is non-empty, load the next entry in the same edge and go to SYNC. Back-to-back frames have no empty gap.
  - Otherwise go to IDLE.
- Checksum: computed combinationally from the frame register; no carry, pure 8-bit XOR.
- busy = (state != IDLE) | !fifo_empty.
- Simultaneous write and serializer pop on a non-full FIFO: both occur and the count is unchanged.
- FIFO pointers are log2(DEPTH)+1 bits, so full and empty are distinguished and wrap is handled.
- Reset mid-frame: the partial frame is discarded, the FIFO is flushed, and tx_empty=1 immediately (async).

Test Plan:
- Single frame: write id=6'h01, data=32'h12345678, hold tx_rd_en=1.
  - Bytes A5,01,78,56,34,12 then checksum 8'h01^78^56^34^12=8'h09.
  - tx_empty falls 2 edges after the write; frame_count=1; busy=0 afterwards.
- Stall: same frame with tx_rd_en pulsed every 3rd cycle.
  - tx_dout holds each byte stably between pops; byte sequence unchanged.
- Back-to-back: write 4 words (ids 0..3), continuous pop.
  - 28 bytes with tx_empty never rising between frames; frame_count=4.
- Full/overflow (DEPTH=4): with tx_rd_en=0, write 5 words.
  - First pops into the frame register, next 4 fill the FIFO (wr_ready=0), sixth write sets overflow_err=1.
  - Writing full while a CSUM pop occurs is still rejected.
- Wrap: send 256 frames, then 1 more.
  - frame_count reads 8'h00 then 8'h01; FIFO pointer wrap produces no data corruption (data=frame index checked).
- Reset mid-frame: assert rst_n=0 after D1 is popped.
  - tx_empty=1, busy=0, frame_count=0, overflow_err=0 asynchronously.
  - A new write then yields a complete, correct frame starting with A5.
